// File: rtl/clock_seq_gen.sv
// clock_seq_gen: reset/hold/run/done sequencer driving NUM_CH divided clock-enable channels
module clock_seq_gen #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 4,
    parameter int RST_HOLD = 2,
    parameter int CNT_W    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic [NUM_CH*DIV_W-1:0] phase_cfg,
    input  logic                    cfg_load,
    input  logic [CNT_W-1:0]        run_limit,
    output logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       ch_clk,
    output logic                    core_rst,
    output logic                    running,
    output logic                    done,
    output logic [CNT_W-1:0]        cycle_count
);
    typedef enum logic [1:0] {RST, HOLD, RUN, DONE} state_t;
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    state_t state, state_n;
    logic [HW-1:0] hold_cnt;
    logic [CNT_W-1:0] limit, count_n;
    logic [NUM_CH-1:0][DIV_W-1:0] sh_div, sh_ph, act_div, act_ph, cnt;
    logic [NUM_CH-1:0][DIV_W-1:0] div_n, ph_n, cnt_n;
    logic [NUM_CH-1:0] wrap, en_n;

    always_comb begin
        count_n = cycle_count + 1'b1;
        state_n = state == RST  ? HOLD
                : state == HOLD ? (hold_cnt == HOLD_LAST ? RUN : HOLD)
                : state == RUN  ? ((limit != '0 && count_n == limit) ? DONE : RUN)
                : DONE;
        wrap = '0;
        cnt_n = '0;
        div_n = '0;
        ph_n = '0;
        en_n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i] = state == RUN && cnt[i] == act_div[i];
            cnt_n[i] = (state == RUN && state_n == RUN && !wrap[i]) ? cnt[i] + 1'b1 : '0;
            div_n[i] = (state inside {RST, HOLD} || wrap[i]) ? sh_div[i] : act_div[i];
            ph_n[i] = (state inside {RST, HOLD} || wrap[i]) ? sh_ph[i] : act_ph[i];
            en_n[i] = state_n == RUN && cnt_n[i] == (ph_n[i] < div_n[i] ? ph_n[i] : div_n[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RST;
            hold_cnt <= '0;
            limit <= '0;
            sh_div <= '0;
            sh_ph <= '0;
            act_div <= '0;
            act_ph <= '0;
            cnt <= '0;
            ch_en <= '0;
            ch_clk <= '0;
            core_rst <= 1'b1;
            running <= 1'b0;
            done <= 1'b0;
            cycle_count <= '0;
        end else begin
            state <= state_n;
            hold_cnt <= state == HOLD ? hold_cnt + 1'b1 : '0;
            if (state == HOLD) limit <= run_limit;
            if (cfg_load) begin
                sh_div <= div_cfg;
                sh_ph <= phase_cfg;
            end
            act_div <= div_n;
            act_ph <= ph_n;
            cnt <= cnt_n;
            ch_en <= en_n;
            ch_clk <= ch_clk ^ ch_en;
            core_rst <= state_n inside {RST, HOLD};
            running <= state_n == RUN;
            done <= state_n == DONE;
            if (state == RUN) cycle_count <= count_n;
        end
    end
endmodule

// File: tb/tb_clock_seq_gen.sv
// tb_clock_seq_gen: scoreboard bench for clock_seq_gen sequencing and channel dividers
module tb_clock_seq_gen;
    logic clock = 1'b0, reset = 1'b0, cfg_load = 1'b0;
    logic [15:0] div_cfg = '0, phase_cfg = '0, run_limit = '0;
    logic [3:0] ch_en, ch_clk;
    logic core_rst, running, done;
    logic [15:0] cycle_count;

    typedef struct packed {
        logic core_rst, running, done;
        logic [3:0] en, clk;
        logic [15:0] cnt;
    } obs_t;

    localparam obs_t IDLE = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0};

    int checks = 0, failures = 0;
    obs_t q[$];
    int md[4], mpe[4], ms[4], md2[4], mpe2[4], mlim;

    clock_seq_gen dut (
        .clock(clock), .reset(reset), .div_cfg(div_cfg), .phase_cfg(phase_cfg),
        .cfg_load(cfg_load), .run_limit(run_limit), .ch_en(ch_en), .ch_clk(ch_clk),
        .core_rst(core_rst), .running(running), .done(done), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic obs_t observed();
        return '{core_rst, running, done, ch_en, ch_clk, cycle_count};
    endfunction

    function automatic void set_model(logic [15:0] d, logic [15:0] p, int lim);
        for (int i = 0; i < 4; i++) begin
            md[i] = int'(d[i*4 +: 4]);
            mpe[i] = int'(p[i*4 +: 4]) < md[i] ? int'(p[i*4 +: 4]) : md[i];
            ms[i] = 1 << 30;
            md2[i] = md[i];
            mpe2[i] = mpe[i];
        end
        mlim = lim;
    endfunction

    // expected outputs in RUN cycle k (or frozen DONE values once the limit is hit)
    function automatic obs_t expect_run(int k);
        obs_t e;
        bit fin;
        int kk;
        fin = mlim != 0 && k >= mlim;
        kk = fin ? mlim : k;
        e = '0;
        e.running = !fin;
        e.done = fin;
        e.cnt = 16'(kk);
        for (int i = 0; i < 4; i++) begin
            int n, r;
            if (kk < ms[i]) begin
                n = (kk + md[i] - mpe[i]) / (md[i] + 1);
                e.en[i] = !fin && (kk % (md[i] + 1)) == mpe[i];
            end else begin
                r = kk - ms[i];
                n = (ms[i] + md[i] - mpe[i]) / (md[i] + 1) + (r + md2[i] - mpe2[i]) / (md2[i] + 1);
                e.en[i] = !fin && (r % (md2[i] + 1)) == mpe2[i];
            end
            e.clk[i] = n[0];
        end
        return e;
    endfunction

    task automatic start_run(input logic [15:0] d, input logic [15:0] p, input logic [15:0] lim);
        reset = 1'b0;
        cfg_load = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        div_cfg = d;
        phase_cfg = p;
        run_limit = lim;
        @(negedge clock);
        cfg_load = 1'b1;
        @(negedge clock);
        cfg_load = 1'b0;
        @(negedge clock);
        set_model(d, p, int'(lim));
    endtask

    task automatic test_reset();
        obs_t o, e;
        reset = 1'b0;
        set_model(16'h0, 16'h0, 0);
        repeat (5) q.push_back(IDLE);
        for (int k = 0; k < 3; k++) q.push_back(expect_run(k));
        @(negedge clock);
        for (int j = 0; j < 8; j++) begin
            o = observed();
            e = q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset j=%0d got=%h exp=%h", j, o, e);
            end
            if (j == 2) reset = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic test_divide();
        obs_t o, e;
        start_run(16'h7310, 16'h0000, 16'd0);
        for (int k = 0; k < 40; k++) q.push_back(expect_run(k));
        for (int j = 0; j < 40; j++) begin
            o = observed();
            e = q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL divide k=%0d got=%h exp=%h", j, o, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_phase_clamp();
        obs_t o, e;
        start_run(16'h4312, 16'h3911, 16'd0);
        for (int k = 0; k < 30; k++) q.push_back(expect_run(k));
        for (int j = 0; j < 30; j++) begin
            o = observed();
            e = q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL phase_clamp k=%0d got=%h exp=%h", j, o, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_run_limit();
        obs_t o, e;
        start_run(16'h7310, 16'h5210, 16'd10);
        for (int k = 0; k < 18; k++) q.push_back(expect_run(k));
        for (int j = 0; j < 18; j++) begin
            o = observed();
            e = q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL run_limit k=%0d got=%h exp=%h", j, o, e);
            end
            if (j == 12) begin
                div_cfg = 16'hFFFF;
                phase_cfg = 16'hFFFF;
                cfg_load = 1'b1;
            end
            if (j == 13) cfg_load = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_reconfig();
        obs_t o, e;
        start_run(16'h7310, 16'h0000, 16'd0);
        ms[1] = 6;
        md2[1] = 3;
        mpe2[1] = 0;
        ms[3] = 8;
        md2[3] = 1;
        mpe2[3] = 0;
        for (int k = 0; k < 24; k++) q.push_back(expect_run(k));
        for (int j = 0; j < 24; j++) begin
            o = observed();
            e = q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reconfig k=%0d got=%h exp=%h", j, o, e);
            end
            if (j == 4) begin
                div_cfg = 16'h2330;
                cfg_load = 1'b1;
            end
            if (j == 5) div_cfg = 16'h1330;
            if (j == 6) cfg_load = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t o, e;
        start_run(16'h7310, 16'h0000, 16'd0);
        for (int k = 0; k < 6; k++) q.push_back(expect_run(k));
        repeat (3) q.push_back(IDLE);
        set_model(16'h0, 16'h0, 0);
        for (int k = 0; k < 6; k++) q.push_back(expect_run(k));
        for (int j = 0; j < 15; j++) begin
            o = observed();
            e = q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_run j=%0d got=%h exp=%h", j, o, e);
            end
            if (j == 5) reset = 1'b0;
            if (j == 6) reset = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic test_count_wrap();
        obs_t o, e;
        start_run(16'h0000, 16'h0000, 16'd0);
        repeat (65534) @(negedge clock);
        for (int k = 65534; k < 65539; k++) q.push_back(expect_run(k));
        for (int j = 0; j < 5; j++) begin
            o = observed();
            e = q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL count_wrap k=%0d got=%h exp=%h", 65534 + j, o, e);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_phase_clamp();
        test_run_limit();
        test_reconfig();
        test_reset_mid_run();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
